pc_stack: RTL
=============

Name: pc_stack

Overview:
Parametrised program counter with a hardware return-address stack for the next-generation Simple CPU. It supports hold, increment, absolute jump, subroutine call and return under one enable. It replaces the load-only PC and sits between the control unit (which drives op/en_pc) and the instruction memory address bus. Stack overflow and underflow are detected and reported with a sticky error flag.

Parameters:
AW, 8, address width in bits (>=4)
DEPTH, 4, return-address stack entries (>=2)
RESET_ADDR, 0, value loaded into adrs_out on reset
INC, 1, increment step applied by INC and used for the CALL return address

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous active-low reset
en_pc  input  1  operation enable; when 0 all state holds
op  input  2  operation: 00 INC, 01 JUMP, 10 CALL, 11 RET
adrs_in  input  AW  jump/call target address
err_clr  input  1  synchronous clear of stk_err
adrs_out  output  AW  current program counter (registered)
top_out  output  AW  top-of-stack entry; 0 when empty
sp_out  output  $clog2(DEPTH+1)  number of valid stack entries
stk_empty  output  1  sp_out == 0
stk_full  output  1  sp_out == DEPTH
stk_err  output  1  sticky overflow/underflow flag

Behaviour:
- Reset is asynchronous on the negedge of clr, active-low. It forces adrs_out=RESET_ADDR, sp=0, all stack entries=0 and stk_err=0. Consequently stk_empty=1, stk_full=0, top_out=0.
- All state updates occur on the rising edge of clk while clr=1. Single-cycle latency: a new adrs_out is visible the cycle after the op is sampled.
- en_pc=0: adrs_out, stack and sp hold. op and adrs_in are ignored. err_clr is still honoured.
- INC: adrs_out <= adrs_out + INC, modulo 2^AW. Wrap-around is silent, e.g. 8'hFF+1 -> 8'h00. The stack is untouched.
- JUMP: adrs_out <= adrs_in. The stack is untouched.
- CALL with stk_full=0:
  - stack[sp] <= adrs_out + INC (modulo 2^AW).
  - sp <= sp+1.
  - adrs_out <= adrs_in.
- CALL with stk_full=1 (overflow): adrs_out, stack and sp hold, and stk_err <= 1.
- RET with stk_empty=0: adrs_out <= stack[sp-1], sp <= sp-1. The popped entry is not cleared.
- RET with stk_empty=1 (underflow): adrs_out and sp hold, and stk_err <= 1.
- top_out = stack[sp-1] when sp>0, else 0. It is combinational from registered state, with no path from inputs.
- stk_empty and stk_full are decoded combinationally from the registered sp only.
- stk_err stays 1 until err_clr=1 on a clock edge or clr=0. If err_clr coincides with a new overflow/underflow, the set wins and stk_err=1.
- A CALL that fills the last slot is legal (sp becomes DEPTH, no error). Only the next CALL errors.
- clr asserted mid-sequence discards the whole stack; after release, the first RET underflows.

Test Plan:
- Reset: hold clr=0 with en_pc=1, op=INC, clocks running -> adrs_out=RESET_ADDR (0), sp_out=0, stk_empty=1, stk_err=0. After release, 3 INC cycles -> adrs_out=3.
- Wrap and hold: JUMP to 8'hFE, then INC, INC -> 8'hFF, 8'h00. Then en_pc=0 for 5 cycles with op=JUMP, adrs_in=8'h55 -> adrs_out stays 8'h00.
- Call/return nesting, DEPTH=4:
  - From 8'h10, CALL 8'h40 -> adrs_out=8'h40, top_out=8'h11, sp_out=1.
  - CALL 8'h80 -> top_out=8'h41, sp_out=2.
  - RET -> adrs_out=8'h41, sp_out=1.
  - RET -> adrs_out=8'h11, sp_out=0, stk_empty=1.
- Overflow: 4 CALLs -> stk_full=1, stk_err=0. 5th CALL to 8'hAA -> adrs_out and sp_out=4 unchanged, stk_err=1. Then err_clr pulse -> stk_err=0.
- Underflow and priority: RET with sp_out=0 -> adrs_out unchanged, stk_err=1. Then err_clr=1 in the same cycle as another RET on empty -> stk_err stays 1.
- Reset mid-operation: after 3 CALLs, pulse clr low between clock edges -> sp_out=0, top_out=0, adrs_out=RESET_ADDR immediately (asynchronous). Next RET -> stk_err=1.

Source files
------------

// File: rtl/pc_stack.sv
// Program counter with a hardware return-address stack: hold, increment,
// jump, call and return under one enable, with sticky overflow/underflow flag.
module pc_stack #(
  parameter int AW         = 8,
  parameter int DEPTH      = 4,
  parameter int RESET_ADDR = 0,
  parameter int INC        = 1
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       en_pc,
  input  logic [1:0]                 op,
  input  logic [AW-1:0]              adrs_in,
  input  logic                       err_clr,
  output logic [AW-1:0]              adrs_out,
  output logic [AW-1:0]              top_out,
  output logic [$clog2(DEPTH+1)-1:0] sp_out,
  output logic                       stk_empty,
  output logic                       stk_full,
  output logic                       stk_err
);

  localparam int SW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  logic [AW-1:0] pc;
  logic [AW-1:0] stack [DEPTH];
  logic [SW-1:0] sp;
  logic          err;

  logic          empty;
  logic          full;
  logic [AW-1:0] ret_addr;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] top_idx;
  logic          do_inc;
  logic          do_jump;
  logic          do_push;
  logic          do_pop;
  logic          overflow;
  logic          underflow;

  assign empty    = (sp == '0);
  assign full     = (sp == SW'(DEPTH));
  assign ret_addr = pc + AW'(INC);
  assign push_idx = IW'(sp);
  assign top_idx  = IW'(sp - SW'(1));

  always_comb begin
    do_inc    = 1'b0;
    do_jump   = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (en_pc) begin
      case (op)
        OP_INC:  do_inc = 1'b1;
        OP_JUMP: do_jump = 1'b1;
        OP_CALL: begin
          do_push  = !full;
          overflow = full;
        end
        OP_RET: begin
          do_pop    = !empty;
          underflow = empty;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc <= AW'(RESET_ADDR);
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else begin
      if (do_inc) begin
        pc <= ret_addr;
      end else if (do_jump) begin
        pc <= adrs_in;
      end else if (do_push) begin
        stack[push_idx] <= ret_addr;
        sp              <= sp + SW'(1);
        pc              <= adrs_in;
      end else if (do_pop) begin
        pc <= stack[top_idx];
        sp <= sp - SW'(1);
      end
    end
  end

  // A new error on the same edge as err_clr must leave the flag set.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      err <= 1'b0;
    end else if (overflow || underflow) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  always_comb begin
    top_out = '0;
    if (!empty) top_out = stack[top_idx];
  end

  assign adrs_out  = pc;
  assign sp_out    = sp;
  assign stk_empty = empty;
  assign stk_full  = full;
  assign stk_err   = err;

endmodule
